// File: rtl/mem_ctrl.sv
// Serialising bridge between the cache and byte-wide main memory: one 8/16/32-bit
// request at a time, one little-endian memory byte access per cycle.

`ifndef IDLE
`define IDLE      2'b00
`endif
`ifndef READ_INST
`define READ_INST 2'b01
`endif
`ifndef READ_DATA
`define READ_DATA 2'b10
`endif
`ifndef WRITE
`define WRITE     2'b11
`endif

module mem_ctrl #(
    parameter int ADDR_WIDTH = 20,
    parameter int LEN        = 32,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_type,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [LEN-1:0]        req_wdata,
    output logic                  resp_valid,
    output logic [LEN-1:0]        resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic [1:0]            mem_vis_signal,
    output logic [BYTE_SIZE-1:0]  writen_data,
    input  logic [BYTE_SIZE-1:0]  mem_data,
    output logic [1:0]            dbg_state
);

    // Handshake: a request is taken on the rising edge where req_valid && req_ready;
    // req_ready is high only in S_IDLE and all req_* inputs are ignored otherwise.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD      = 2'd1,
        S_RD_TAIL = 2'd2,
        S_WR      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cyc_q, cyc_d;
    logic [1:0]            type_q, type_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic [LEN-1:0]        wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] mem_vis_addr_q, mem_vis_addr_d;
    logic [1:0]            mem_vis_signal_q, mem_vis_signal_d;
    logic [BYTE_SIZE-1:0]  writen_data_q, writen_data_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [LEN-1:0]        resp_rdata_q, resp_rdata_d;

    logic [1:0]            issue_idx;
    logic [1:0]            smp_idx;
    logic [2:0]            req_n;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [LEN-1:0] low_mask(input logic [2:0] n);
        logic [LEN-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(n)) begin
                m[BYTE_SIZE*i +: BYTE_SIZE] = {BYTE_SIZE{1'b1}};
            end
        end
        return m;
    endfunction

    // cyc_q counts edges since acceptance: byte cyc_q is issued, byte cyc_q-2 returns.
    assign issue_idx = cyc_q[1:0];
    assign smp_idx   = 2'(cyc_q - 3'd2);
    assign req_n     = size_to_n(req_size);

    always_comb begin
        state_d          = state_q;
        cyc_d            = cyc_q;
        type_d           = type_q;
        base_d           = base_q;
        nbytes_d         = nbytes_q;
        wdata_d          = wdata_q;
        mem_vis_addr_d   = mem_vis_addr_q;
        mem_vis_signal_d = `IDLE;
        writen_data_d    = writen_data_q;
        resp_valid_d     = 1'b0;
        resp_rdata_d     = resp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    type_d         = req_type;
                    base_d         = req_addr;
                    nbytes_d       = req_n;
                    wdata_d        = req_wdata;
                    cyc_d          = 3'd1;
                    mem_vis_addr_d = req_addr;
                    if (req_type == `WRITE) begin
                        mem_vis_signal_d = `WRITE;
                        writen_data_d    = req_wdata[BYTE_SIZE-1:0];
                        state_d          = S_WR;
                    end else begin
                        mem_vis_signal_d = req_type;
                        resp_rdata_d     = resp_rdata_q & low_mask(req_n);
                        state_d          = S_RD;
                    end
                end
            end

            S_RD: begin
                cyc_d = cyc_q + 3'd1;
                if (cyc_q >= 3'd2) begin
                    resp_rdata_d[BYTE_SIZE*smp_idx +: BYTE_SIZE] = mem_data;
                end
                if (cyc_q < nbytes_q) begin
                    mem_vis_signal_d = type_q;
                    mem_vis_addr_d   = base_q + ADDR_WIDTH'(cyc_q);
                end else begin
                    state_d = S_RD_TAIL;
                end
            end

            S_RD_TAIL: begin
                // Last byte arrives now; the response is visible next cycle.
                resp_rdata_d[BYTE_SIZE*smp_idx +: BYTE_SIZE] = mem_data;
                resp_valid_d = 1'b1;
                cyc_d        = 3'd0;
                state_d      = S_IDLE;
            end

            S_WR: begin
                cyc_d = cyc_q + 3'd1;
                if (cyc_q < nbytes_q) begin
                    mem_vis_signal_d = `WRITE;
                    mem_vis_addr_d   = base_q + ADDR_WIDTH'(cyc_q);
                    writen_data_d    = wdata_q[BYTE_SIZE*issue_idx +: BYTE_SIZE];
                end else begin
                    resp_valid_d = 1'b1;
                    cyc_d        = 3'd0;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cyc_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            cyc_q            <= 3'd0;
            type_q           <= 2'd0;
            base_q           <= '0;
            nbytes_q         <= 3'd0;
            wdata_q          <= '0;
            mem_vis_addr_q   <= '0;
            mem_vis_signal_q <= `IDLE;
            writen_data_q    <= '0;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
        end else begin
            state_q          <= state_d;
            cyc_q            <= cyc_d;
            type_q           <= type_d;
            base_q           <= base_d;
            nbytes_q         <= nbytes_d;
            wdata_q          <= wdata_d;
            mem_vis_addr_q   <= mem_vis_addr_d;
            mem_vis_signal_q <= mem_vis_signal_d;
            writen_data_q    <= writen_data_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_vis_addr   = mem_vis_addr_q;
    assign mem_vis_signal = mem_vis_signal_q;
    assign writen_data    = writen_data_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide memory model, directed vector table,
// back-to-back and mid-write reset sequences, then randomized requests vs a reference model.

module tb_mem_ctrl;

    localparam logic [1:0] C_IDLE = 2'b00;
    localparam logic [1:0] C_RI   = 2'b01;
    localparam logic [1:0] C_RD   = 2'b10;
    localparam logic [1:0] C_WR   = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_type = 2'b00;
    logic [19:0] req_addr = 20'h0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [19:0] mem_vis_addr;
    logic [1:0]  mem_vis_signal;
    logic [7:0]  writen_data;
    logic [7:0]  mem_data = 8'h00;
    logic [1:0]  dbg_state;

    logic [7:0]  mem     [0:1048575];
    logic [7:0]  ref_mem [0:1048575];
    logic        bd_we = 1'b0;
    logic [19:0] bd_addr = 20'h0;
    logic [7:0]  bd_data = 8'h00;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rd;
    logic [1:0]  nxt_type;
    logic [19:0] nxt_addr;
    logic [1:0]  nxt_size;
    logic [31:0] nxt_wdata;

    typedef struct {
        logic [1:0]  t;
        logic [19:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    mem_ctrl #(.ADDR_WIDTH(20), .LEN(32), .BYTE_SIZE(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_type       (req_type),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_vis_addr   (mem_vis_addr),
        .mem_vis_signal (mem_vis_signal),
        .writen_data    (writen_data),
        .mem_data       (mem_data),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    // Main memory: writes commit on the edge after issue, read data appears one cycle after issue.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_vis_signal == C_WR) begin
            mem[mem_vis_addr] <= writen_data;
        end else if (mem_vis_signal == C_RI || mem_vis_signal == C_RD) begin
            mem_data <= mem[mem_vis_addr];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    task automatic poke(input logic [19:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Reference: a request touches bytes a..a+N-1 (wrapping); reads return them zero-extended.
    task automatic model_req(input logic [1:0] t, input logic [19:0] a, input logic [1:0] sz,
                             input logic [31:0] wd, output logic [31:0] exp);
        int n;
        n = nbytes(sz);
        exp = 32'h0;
        if (t == C_WR) begin
            for (int i = 0; i < n; i++) ref_mem[a + 20'(i)] = wd[8*i +: 8];
            exp = last_rd;
        end else begin
            for (int i = 0; i < n; i++) exp[8*i +: 8] = ref_mem[a + 20'(i)];
            last_rd = exp;
        end
    endtask

    // Called just after a negedge; returns at the negedge inside the response cycle.
    task automatic run_req(input string nm, input logic [1:0] t, input logic [19:0] a,
                           input logic [1:0] sz, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input bit hold);
        int          n;
        int          lat;
        logic [19:0] ea;
        n   = nbytes(sz);
        lat = (t == C_WR) ? n : n + 1;
        check({nm, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_size  = sz;
        req_wdata = wd;
        @(posedge clk);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (hold) begin
                    req_type  = nxt_type;
                    req_addr  = nxt_addr;
                    req_size  = nxt_size;
                    req_wdata = nxt_wdata;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (k < n) begin
                ea = a + 20'(k);
                check($sformatf("%s cmd[%0d]", nm, k), 32'(mem_vis_signal), 32'(t));
                check($sformatf("%s addr[%0d]", nm, k), 32'(mem_vis_addr), 32'(ea));
                if (t == C_WR)
                    check($sformatf("%s wbyte[%0d]", nm, k), 32'(writen_data), 32'(wd[8*k +: 8]));
            end else begin
                check($sformatf("%s cmd_idle[%0d]", nm, k), 32'(mem_vis_signal), 32'(C_IDLE));
            end
            check($sformatf("%s resp_valid[%0d]", nm, k), 32'(resp_valid),
                  (k == lat) ? 32'd1 : 32'd0);
            if (k == lat) begin
                check({nm, " rdata"}, resp_rdata, exp_rd);
                check({nm, " ready_in_resp"}, 32'(req_ready), 32'd1);
            end
        end
    endtask

    task automatic idle_check(input string nm);
        @(negedge clk);
        check({nm, " idle resp_valid"}, 32'(resp_valid), 32'd0);
        check({nm, " idle cmd"}, 32'(mem_vis_signal), 32'(C_IDLE));
        check({nm, " idle ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] exp;
        logic [1:0]  t;
        logic [19:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        int          rv_seen;

        vecs[0]  = '{C_RD, 20'h00100, 2'd2, 32'h0,        32'h44332211};
        vecs[1]  = '{C_WR, 20'h00200, 2'd2, 32'hDEADBEEF, 32'h44332211};
        vecs[2]  = '{C_RD, 20'h00202, 2'd0, 32'h0,        32'h000000AD};
        vecs[3]  = '{C_RD, 20'hFFFFF, 2'd1, 32'h0,        32'h0000A55A};
        vecs[4]  = '{C_RI, 20'h00101, 2'd0, 32'h0,        32'h00000022};
        vecs[5]  = '{C_WR, 20'hFFFFE, 2'd3, 32'h01020304, 32'h00000022};
        vecs[6]  = '{C_RD, 20'hFFFFF, 2'd2, 32'h0,        32'h77010203};
        vecs[7]  = '{C_WR, 20'h00400, 2'd1, 32'hAAAABEEF, 32'h77010203};
        vecs[8]  = '{C_RI, 20'h00400, 2'd3, 32'h0,        32'h9900BEEF};
        vecs[9]  = '{C_WR, 20'h00500, 2'd0, 32'hFFFFFF5C, 32'h9900BEEF};
        vecs[10] = '{C_RD, 20'h00500, 2'd0, 32'h0,        32'h0000005C};

        // Preload memory while the controller is held in reset.
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) poke(20'h00800 + 20'(i), 8'($urandom));
        for (int i = 0; i < 16; i++) poke(20'hFFFF8 + 20'(i), 8'($urandom));
        poke(20'h00100, 8'h11); poke(20'h00101, 8'h22);
        poke(20'h00102, 8'h33); poke(20'h00103, 8'h44);
        poke(20'hFFFFF, 8'h5A); poke(20'h00000, 8'hA5); poke(20'h00002, 8'h77);
        poke(20'h00402, 8'h00); poke(20'h00403, 8'h99);
        poke(20'h00300, 8'hC0); poke(20'h00301, 8'hC1);
        poke(20'h00302, 8'hC2); poke(20'h00303, 8'hC3);
        last_rd = 32'h0;
        rst = 1'b1;

        for (int i = 0; i < 3; i++) idle_check($sformatf("reset%0d", i));
        check("reset addr", 32'(mem_vis_addr), 32'h0);
        check("reset wdata", 32'(writen_data), 32'h0);
        check("reset rdata", resp_rdata, 32'h0);

        for (int i = 0; i < 11; i++) begin
            model_req(vecs[i].t, vecs[i].a, vecs[i].sz, vecs[i].wd, exp);
            run_req($sformatf("vec%0d", i), vecs[i].t, vecs[i].a, vecs[i].sz, vecs[i].wd,
                    vecs[i].exp_rd, 1'b0);
            idle_check($sformatf("vec%0d", i));
        end

        // Back-to-back: second request held valid throughout the first.
        nxt_type = C_RD; nxt_addr = 20'h00103; nxt_size = 2'd0; nxt_wdata = 32'hFFFFFFFF;
        model_req(C_RI, 20'h00100, 2'd0, 32'h0, exp);
        run_req("b2b_first", C_RI, 20'h00100, 2'd0, 32'h0, 32'h00000011, 1'b1);
        model_req(nxt_type, nxt_addr, nxt_size, nxt_wdata, exp);
        run_req("b2b_second", nxt_type, nxt_addr, nxt_size, nxt_wdata, 32'h00000044, 1'b0);
        idle_check("b2b");

        // Reset after bytes 0 and 1 of a word write have committed.
        check("rst_wr req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_type = C_WR; req_addr = 20'h00300;
        req_size = 2'd2; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wr cmd", 32'(mem_vis_signal), 32'(C_IDLE));
        check("rst_wr addr", 32'(mem_vis_addr), 32'h0);
        check("rst_wr wdata", 32'(writen_data), 32'h0);
        check("rst_wr resp_valid", 32'(resp_valid), 32'd0);
        check("rst_wr ready", 32'(req_ready), 32'd1);
        check("rst_wr rdata", resp_rdata, 32'h0);
        ref_mem[20'h00300] = 8'h78;
        ref_mem[20'h00301] = 8'h56;
        last_rd = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) rv_seen++;
        end
        check("rst_wr no_resp", 32'(rv_seen), 32'd0);
        check("rst_wr mem300", 32'(mem[20'h00300]), 32'h78);
        check("rst_wr mem301", 32'(mem[20'h00301]), 32'h56);
        check("rst_wr mem302", 32'(mem[20'h00302]), 32'hC2);
        check("rst_wr mem303", 32'(mem[20'h00303]), 32'hC3);

        // Randomized traffic, some of it back-to-back, inside the preloaded windows.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       t = C_RI;
                1:       t = C_RD;
                default: t = C_WR;
            endcase
            if ($urandom_range(0, 1) == 1) a = 20'h00800 + 20'($urandom_range(0, 56));
            else                           a = 20'hFFFF8 + 20'($urandom_range(0, 7));
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            model_req(t, a, sz, wd, exp);
            run_req($sformatf("rand%0d", i), t, a, sz, wd, exp, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", i));
        end
        idle_check("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
